// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset datapath.
// Shares one memory port via mem_ready, counts retired instructions, traps port hangs.
module multicycle_ctrl #(
  parameter int CNT_WIDTH  = 32,
  parameter int WAIT_LIMIT = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Function_opcode,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic [2:0]           state,
  output logic                 PCWrite,
  output logic [1:0]           PCSource,
  output logic                 IRWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic [1:0]           RegDST,
  output logic                 ALUSrc,
  output logic [1:0]           ALUOp,
  output logic                 Sftmd,
  output logic                 I_format,
  output logic                 instr_done,
  output logic                 illegal,
  output logic                 bus_error,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5
  } state_t;

  localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

  state_t        cur, nxt;
  logic [WW-1:0] wait_cnt, wait_inc;
  logic          stalled, timeout;

  logic r_fmt, i_fmt, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr, is_sft, legal;

  assign r_fmt  = (Opcode == 6'h00);
  assign i_fmt  = (Opcode[5:3] == 3'b001);
  assign is_lw  = (Opcode == 6'h23);
  assign is_sw  = (Opcode == 6'h2B);
  assign is_beq = (Opcode == 6'h04);
  assign is_bne = (Opcode == 6'h05);
  assign is_j   = (Opcode == 6'h02);
  assign is_jal = (Opcode == 6'h03);
  assign is_jr  = r_fmt && (Function_opcode == 6'h08);
  assign is_sft = r_fmt && (Function_opcode == 6'h00 || Function_opcode == 6'h02 ||
                            Function_opcode == 6'h03 || Function_opcode == 6'h04 ||
                            Function_opcode == 6'h06 || Function_opcode == 6'h07);
  assign legal  = r_fmt || i_fmt || is_lw || is_sw || is_beq || is_bne || is_j || is_jal;

  // Hang detection: consecutive no-ready cycles in the two memory-port states
  assign stalled  = (cur == FETCH || cur == MEM) && !mem_ready;
  assign wait_inc = wait_cnt + 1'b1;
  assign timeout  = (WAIT_LIMIT != 0) && stalled && (wait_inc == WW'(WAIT_LIMIT));

  assign state = cur;

  always_comb begin
    nxt        = cur;
    PCWrite    = 1'b0;
    PCSource   = 2'd0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    RegDST     = 2'd0;
    ALUSrc     = 1'b0;
    ALUOp      = 2'd0;
    Sftmd      = 1'b0;
    I_format   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;

    if (cur == EXEC || cur == MEM || cur == WB) begin
      ALUOp    = {r_fmt | i_fmt, is_beq | is_bne};
      Sftmd    = is_sft;
      I_format = i_fmt;
      ALUSrc   = i_fmt | is_lw | is_sw;
    end

    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          nxt     = DECODE;
        end
      end
      DECODE: begin
        if (is_j || is_jal) begin
          PCWrite    = 1'b1;
          PCSource   = 2'd2;
          RegWrite   = is_jal;
          RegDST     = is_jal ? 2'd2 : 2'd0;
          instr_done = 1'b1;
          nxt        = FETCH;
        end else if (is_jr) begin
          PCWrite    = 1'b1;
          PCSource   = 2'd3;
          instr_done = 1'b1;
          nxt        = FETCH;
        end else if (!legal) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          nxt        = FETCH;
        end else begin
          nxt = EXEC;
        end
      end
      EXEC: begin
        if (is_beq || is_bne) begin
          PCSource   = 2'd1;
          PCWrite    = is_beq ? Zero : !Zero;
          instr_done = 1'b1;
          nxt        = FETCH;
        end else if (is_lw || is_sw) begin
          nxt = MEM;
        end else begin
          nxt = WB;
        end
      end
      MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (mem_ready) begin
          instr_done = is_sw;
          nxt        = is_sw ? FETCH : WB;
        end
      end
      WB: begin
        RegWrite   = 1'b1;
        RegDST     = r_fmt ? 2'd1 : 2'd0;
        MemtoReg   = is_lw;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      default: nxt = HALT;
    endcase

    if (timeout) nxt = HALT;

    // Reset masks every control so a half-finished memory request is dropped at once
    if (reset) begin
      PCWrite    = 1'b0;
      PCSource   = 2'd0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      RegDST     = 2'd0;
      ALUSrc     = 1'b0;
      ALUOp      = 2'd0;
      Sftmd      = 1'b0;
      I_format   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur       <= FETCH;
      retired   <= '0;
      bus_error <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      cur <= nxt;
      if (instr_done) retired <= retired + CNT_WIDTH'(1);
      if (timeout) bus_error <= 1'b1;
      wait_cnt <= (stalled && nxt == cur && WAIT_LIMIT != 0) ? wait_inc : '0;
    end
  end

endmodule
